// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 bus master: command encoding, FSM states and
// strobe-length defaults.
package z80_bus_pkg;

   localparam logic [1:0] CMD_MEMRD = 2'd0;
   localparam logic [1:0] CMD_MEMWR = 2'd1;
   localparam logic [1:0] CMD_IORD  = 2'd2;
   localparam logic [1:0] CMD_IOWR  = 2'd3;

   localparam int MEM_STB_DEF = 4;
   localparam int IO_STB_DEF  = 6;

   // The strobe counter holds N-1 at most, so size it from the longer strobe.
   localparam int STB_MAX = (MEM_STB_DEF > IO_STB_DEF) ? MEM_STB_DEF : IO_STB_DEF;
   localparam int CNT_W   = $clog2(STB_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      STRB  = 2'd2,
      RECOV = 2'd3
   } bus_state_t;

endpackage

// File: rtl/z80_bus_master.sv
// Z80-style bus cycle generator: turns a req/cmd/addr transaction into
// MREQ/IORQ/RD/WR strobe sequences with WAIT stretching.
//
// state | meaning
// IDLE  | ready for a request; bus holds the previous address
// ADDR  | address and write data on the bus, strobes still high
// STRB  | strobes low; counts down N cycles then honours wait_n
// RECOV | strobes released, data bus still driven for writes
module z80_bus_master
   import z80_bus_pkg::*;
#(
   parameter int MEM_STB = MEM_STB_DEF,
   parameter int IO_STB  = IO_STB_DEF
)(
   input  logic        clkin,
   input  logic        coldres,
   input  logic        req,
   input  logic [1:0]  cmd,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   output logic        ready,
   output logic        done,
   output logic [7:0]  rdata,
   output logic [15:0] zaddr,
   output logic [7:0]  zdout,
   output logic        zdena,
   input  logic [7:0]  zdin,
   output logic        mreq_n,
   output logic        iorq_n,
   output logic        rd_n,
   output logic        wr_n,
   input  logic        wait_n
);

   localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_STB - 1);
   localparam logic [CNT_W-1:0] IO_LOAD  = CNT_W'(IO_STB - 1);

   bus_state_t       state;
   bus_state_t       state_nxt;
   logic [1:0]       cmd_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_load;
   logic             strb_end;

   assign cnt_load = cmd_q[1] ? IO_LOAD : MEM_LOAD;
   assign strb_end = (cnt == '0) && wait_n;

   always_ff @(posedge clkin) begin
      if (coldres) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = ADDR;
         ADDR:    state_nxt = STRB;
         STRB:    if (strb_end) state_nxt = RECOV;
         RECOV:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes decode straight from the state so they move on the same edge
   // as the state change; zdena spans ADDR..RECOV for writes.
   always_comb begin
      ready  = (state == IDLE);
      mreq_n = 1'b1;
      iorq_n = 1'b1;
      rd_n   = 1'b1;
      wr_n   = 1'b1;
      zdena  = cmd_q[0] && (state != IDLE);
      if (state == STRB) begin
         mreq_n = cmd_q[1];
         iorq_n = ~cmd_q[1];
         rd_n   = cmd_q[0];
         wr_n   = ~cmd_q[0];
      end
   end

   always_ff @(posedge clkin) begin
      if (coldres) begin
         cmd_q <= CMD_MEMRD;
         cnt   <= '0;
         zaddr <= 16'h0000;
         zdout <= 8'h00;
         rdata <= 8'h00;
         done  <= 1'b0;
      end else begin
         done <= (state == RECOV);
         case (state)
            IDLE: begin
               if (req) begin
                  cmd_q <= cmd;
                  zaddr <= addr;
                  zdout <= wdata;
               end
            end
            ADDR: cnt <= cnt_load;
            STRB: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (wait_n && !cmd_q[0]) begin
                  rdata <= zdin;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
